conv2d_stream: RTL and testbench
================================

CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels, minimum 3.
REQ-002 Parameter IMG_H, default 8: image height in pixels, minimum 3.
REQ-003 Parameter DATA_W, default 8: unsigned pixel width.
REQ-004 Parameter COEF_W, default 8: signed two's-complement coefficient width.
REQ-005 Parameter OUT_W, default 16: signed result width.
REQ-006 Parameter SHIFT, default 0: arithmetic right shift applied to the full-precision sum.
REQ-007 Parameter SAT, default 1: 1 = saturate to the OUT_W signed range, 0 = keep the low OUT_W bits.
REQ-008 Port clk  input  1  single clock; all logic on its rising edge.
REQ-009 Port rst_n  input  1  asynchronous active-low reset.
REQ-010 Port start  input  1  one-cycle frame start request.
REQ-011 Port coef_we  input  1  coefficient write strobe.
REQ-012 Port coef_addr  input  4  coefficient index 0..8, row-major; 9..15 ignored.
REQ-013 Port coef_din  input  COEF_W  coefficient write data.
REQ-014 Port in_valid  input  1  pixel valid.
REQ-015 Port in_ready  output  1  pixel accept; transfer when in_valid && in_ready.
REQ-016 Port in_data  input  DATA_W  pixel, raster order.
REQ-017 Port out_valid  output  1  result valid.
REQ-018 Port out_ready  input  1  result accept; transfer when out_valid && out_ready.
REQ-019 Port out_data  output  OUT_W  convolution result.
REQ-020 Port out_last  output  1  marks the final result of a frame.
REQ-021 Port busy  output  1  frame in progress.
REQ-022 Port done  output  1  one-cycle pulse at frame completion.

Function
REQ-023 The FSM SHALL have three states:
- IDLE: start -> STREAM, clears row/col counters; busy=1 from the next cycle.
- STREAM: acceptance of pixel (IMG_H-1, IMG_W-1) -> FLUSH.
- FLUSH: acceptance of the out_last result -> IDLE with done=1 for one cycle.
REQ-024 Start SHALL be ignored outside IDLE.
REQ-025 A coefficient write SHALL take effect only in IDLE; writes while busy=1 or with coef_addr>8 SHALL be ignored.
REQ-026 in_ready SHALL equal (state==STREAM) && (!out_valid || out_ready).
REQ-027 Two IMG_W-deep line buffers plus a 3x3 window register SHALL hold the two previous rows and the current row.
REQ-028 Each accepted pixel at (r,c) with r>=2 and c>=2 SHALL produce exactly one result over window rows r-2..r and cols c-2..c.
REQ-029 Window/coefficient mapping: coefficient k=3*kr+kc multiplies pixel (r-2+kr, c-2+kc).
REQ-030 That result SHALL be registered into out_data/out_valid on the clock edge of acceptance (latency 1 cycle).
REQ-031 Pixels with r<2 or c<2 SHALL produce no output; output count per frame = (IMG_H-2)*(IMG_W-2), raster order.
REQ-032 Arithmetic: pixel zero-extended to signed; nine products and their sum kept at full precision (DATA_W+COEF_W+4 bits); then >>>SHIFT; then saturate or truncate per SAT.
REQ-033 out_valid SHALL hold, with out_data/out_last stable, until out_ready; when out_ready=1 and a new pixel is accepted in the same cycle, the new result SHALL replace the old without a bubble.
REQ-034 out_last SHALL be 1 only with the result for pixel (IMG_H-1, IMG_W-1).
REQ-035 Column wrap: col returns to 0 after IMG_W-1 and row increments; the window SHALL NOT mix pixels across a row boundary.

Reset
REQ-036 On rst_n low, regardless of clock, the block SHALL reset to:
- state=IDLE;
- busy, done, in_ready, out_valid, out_last = 0;
- out_data = 0;
- counters = 0;
- all coefficients = 0.
REQ-037 A reset mid-frame SHALL discard the partial frame; after release the block SHALL wait for a new start.

Verification
REQ-038 Identity kernel (coef4=1, others 0), 8x8 ramp pixel=8r+c, out_ready=1 -> 36 results, result j = 8*(j/6+1)+(j%6+1), first=9, last=54 with out_last.
REQ-039 All coefficients 127, all pixels 255: SAT=1 -> every out_data=32767; SAT=0 -> every out_data=16'h7289.
REQ-040 All coefficients -128, all pixels 255, SAT=1 -> every out_data=-32768 (16'h8000).
REQ-041 Identity kernel, out_ready held 0 for 20 cycles after the first out_valid -> out_valid and out_data stay 9, in_ready stays 0, and all 36 results still arrive in order.
REQ-042 rst_n pulsed low after 30 accepted pixels -> outputs zeroed immediately, busy=0; a new start with coefficients reloaded -> a correct full 36-result frame followed by a single done pulse.
REQ-043 start asserted during STREAM and coef_we during FLUSH -> no counter restart, coefficients unchanged, results identical to an undisturbed run.

Source files
------------

// File: rtl/conv2d_stream.sv
// Streaming 3x3 convolution over a raster-order IMG_W x IMG_H frame.
// Two line buffers plus a two-column window feed one fully parallel MAC per accepted pixel.
module conv2d_stream #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_din,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = DATA_W + COEF_W + 4;
  localparam logic signed [SUM_W-1:0] OMAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OMIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  state_e                   state_q, state_d;
  logic [RW-1:0]            row_q;
  logic [CW-1:0]            col_q;
  logic signed [COEF_W-1:0] coef_q [9];
  logic [DATA_W-1:0]        lb0_q [IMG_W];
  logic [DATA_W-1:0]        lb1_q [IMG_W];
  logic [DATA_W-1:0]        win_q [3][2];
  logic [DATA_W-1:0]        tap [3];
  logic [DATA_W-1:0]        pix;
  logic signed [PROD_W-1:0] px_ext, cf_ext, prod;
  logic signed [SUM_W-1:0]  sum, shifted;
  logic signed [OUT_W-1:0]  res;
  logic                     accept, last_pix, produce, out_fire;

  function automatic logic signed [OUT_W-1:0] fit_out(input logic signed [SUM_W-1:0] v);
    if (SAT != 0 && v > OMAX) return OMAX[OUT_W-1:0];
    if (SAT != 0 && v < OMIN) return OMIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  assign in_ready = (state_q == STREAM) && (!out_valid || out_ready);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_pix = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
  assign produce  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Incoming column: rows r-2, r-1 from the line buffers, row r from the input.
  assign tap[0] = lb0_q[col_q];
  assign tap[1] = lb1_q[col_q];
  assign tap[2] = in_data;

  always_comb begin
    sum    = '0;
    pix    = '0;
    px_ext = '0;
    cf_ext = '0;
    prod   = '0;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        pix    = (kc == 2) ? tap[kr] : win_q[kr][kc];
        px_ext = PROD_W'($signed({1'b0, pix}));
        cf_ext = PROD_W'(coef_q[3*kr+kc]);
        prod   = px_ext * cf_ext;
        sum    = sum + SUM_W'(prod);
      end
    end
    shifted = sum >>> SHIFT;
    res     = fit_out(shifted);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && last_pix) state_d = FLUSH;
      FLUSH:   if (out_fire && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < 9; k++) coef_q[k] <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == FLUSH) && out_fire && out_last;
      if (state_q == IDLE && start) begin
        row_q <= '0;
        col_q <= '0;
      end else if (accept) begin
        if (col_q == CW'(IMG_W-1)) begin
          col_q <= '0;
          row_q <= last_pix ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (state_q == IDLE && coef_we) begin
        for (int k = 0; k < 9; k++)
          if (coef_addr == 4'(k)) coef_q[k] <= coef_din;
      end
      // A new result may overwrite the held one only in a cycle where it drains.
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_last  <= last_pix;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_data;
      for (int kr = 0; kr < 3; kr++) begin
        win_q[kr][0] <= win_q[kr][1];
        win_q[kr][1] <= tap[kr];
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream: table of kernel/image cases plus a mid-frame reset sequence.
module tb_conv2d_stream;

  localparam int W = 8, H = 8, NPIX = 64, NOUT = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, coef_we, in_valid, out_ready;
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_din;
  logic [7:0]        in_data;
  logic              in_ready, out_valid, out_last, busy, done;
  logic signed [15:0] out_data;
  logic              in_ready_n, out_valid_n, out_last_n, busy_n, done_n;
  logic signed [15:0] out_data_n;

  conv2d_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .COEF_W(8), .OUT_W(16), .SHIFT(0), .SAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_din(coef_din), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done));

  conv2d_stream #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .COEF_W(8), .OUT_W(16), .SHIFT(0), .SAT(0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_din(coef_din), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .out_last(out_last_n),
    .busy(busy_n), .done(done_n));

  typedef struct {
    int ck[9];
    int pk;       // 0 = ramp 8r+c, 1 = all 255
    int ef;       // first result, saturating instance
    int el;       // last result, saturating instance
    int enf;      // first result, truncating instance
    int stall;
    int disturb;
    int load;
  } vec_t;

  vec_t vec[9];
  int   checks = 0, errors = 0;
  int   mc[9];
  int   got[$], got_n[$];
  bit   got_last[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic int pixval(input int pk, input int r, input int c);
    return (pk == 0) ? 8*r + c : 255;
  endfunction

  function automatic longint model(input int pk, input int r, input int c);
    longint s = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        s += longint'(mc[3*kr+kc]) * pixval(pk, r-2+kr, c-2+kc);
    return s;
  endfunction

  function automatic longint sat16(input longint s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic longint trunc16(input longint s);
    logic signed [15:0] t;
    t = s[15:0];
    return t;
  endfunction

  task automatic load_coefs();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 4'(k); coef_din = 8'(mc[k]);
    end
    @(negedge clk);
    coef_addr = 4'd12; coef_din = 8'sd7;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic run_frame(input int pk, input int stall, input int disturb,
                           input int ef, input int el, input int enf);
    int pi = 0, cyc = 0, ndone = 0, post = 0, stall_left = 0;
    bit first_seen = 1'b0, fw = 1'b0;
    got.delete(); got_n.delete(); got_last.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_after_start", busy, 1);
    while (cyc < 600 && post < 4) begin
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        stall_left = stall;
      end
      out_ready = (stall_left == 0);
      in_valid  = (pi < NPIX);
      in_data   = 8'(pixval(pk, pi / W, pi % W));
      start     = (disturb != 0) && (pi == 10);
      coef_we   = (disturb != 0) && ((pi == 20) || (pi == NPIX && busy && !fw));
      if (pi == NPIX && coef_we) fw = 1'b1;
      coef_addr = 4'd4;
      coef_din  = 8'sd5;
      #1;
      if (stall_left > 0) begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, ef);
        chk("stall_in_ready", in_ready, 0);
        stall_left--;
      end
      if (in_valid && in_ready) pi++;
      if (out_valid && out_ready) begin
        got.push_back(int'(out_data));
        got_n.push_back(int'(out_data_n));
        got_last.push_back(out_last);
      end
      if (done) ndone++;
      if (ndone > 0) post++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    if (post < 4) begin
      checks++; errors++;
      $display("FAIL frame_timeout: actual %0d results required %0d", got.size(), NOUT);
    end
    chk("done_pulses", ndone, 1);
    chk("result_count", got.size(), NOUT);
    #1 chk("busy_after_done", busy, 0);
    for (int j = 0; j < got.size(); j++) begin
      chk("result", got[j], sat16(model(pk, j/(W-2) + 2, j%(W-2) + 2)));
      chk("result_nosat", got_n[j], trunc16(model(pk, j/(W-2) + 2, j%(W-2) + 2)));
      chk("last_flag", got_last[j], (j == NOUT-1));
    end
    if (got.size() == NOUT) begin
      chk("first_hand", got[0], ef);
      chk("last_hand", got[NOUT-1], el);
      chk("first_nosat_hand", got_n[0], enf);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int pi, cyc, seen;
    vec[0] = '{'{0,0,0,0,1,0,0,0,0}, 0, 9, 54, 9, 0, 0, 1};
    vec[1] = '{'{127,127,127,127,127,127,127,127,127}, 1, 32767, 32767, 29321, 0, 0, 1};
    vec[2] = '{'{-128,-128,-128,-128,-128,-128,-128,-128,-128}, 1, -32768, -32768, -31616, 0, 0, 1};
    vec[3] = '{'{-1,0,1,-2,0,2,-1,0,1}, 0, 8, 8, 8, 0, 0, 1};
    vec[4] = '{'{-1,-2,-1,0,0,0,1,2,1}, 0, 64, 64, 64, 0, 0, 1};
    vec[5] = '{'{-1,-1,-1,-1,-1,-1,-1,-1,-1}, 0, -81, -486, -81, 0, 0, 1};
    vec[6] = '{'{0,0,0,0,1,0,0,0,0}, 0, 9, 54, 9, 20, 0, 1};
    vec[7] = '{'{0,0,0,0,1,0,0,0,0}, 0, 9, 54, 9, 0, 1, 1};
    vec[8] = '{'{0,0,0,0,1,0,0,0,0}, 0, 9, 54, 9, 0, 0, 0};

    start = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_din = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vec[i].load != 0) begin
        for (int k = 0; k < 9; k++) mc[k] = vec[i].ck[k];
        load_coefs();
      end
      run_frame(vec[i].pk, vec[i].stall, vec[i].disturb, vec[i].ef, vec[i].el, vec[i].enf);
    end

    // Mid-frame reset after 30 accepted pixels.
    mc = '{0,0,0,0,1,0,0,0,0};
    load_coefs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    pi = 0; cyc = 0;
    while (pi < 30 && cyc < 200) begin
      in_data = 8'(pixval(0, pi / W, pi % W));
      #1;
      if (in_valid && in_ready) pi++;
      cyc++;
      @(negedge clk);
    end
    chk("pre_reset_accepts", pi, 30);
    #1 chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      #1 if (in_ready) seen++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("wait_for_start", seen, 0);
    mc = '{0,0,0,0,0,0,0,0,0};
    run_frame(0, 0, 0, 0, 0, 0);
    mc = '{0,0,0,0,1,0,0,0,0};
    load_coefs();
    run_frame(0, 0, 0, 9, 54, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
